// File: rtl/calc_pkg.sv
// Shared calculator definitions: display codes understood by the bcd2seg chain
// and the operand-entry state encoding.
package calc_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_MINUS = 4'hA;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } entry_state_t;

endpackage

// File: rtl/key_edge.sv
// Vector of rising-edge detectors on already-debounced key levels.
// The event pulse is registered, so it lasts exactly one cycle per key press.
module key_edge #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] level,
    output logic [N-1:0] rise
);

    logic [N-1:0] prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= '0;
            rise <= '0;
        end else begin
            prev <= level;
            rise <= level & ~prev;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Keypad front end: accumulates signed decimal operands A and B plus a function
// code, converts them to two's complement and exposes the live entry as BCD.
module operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              key_digit,
    input  logic                    key_dstb,
    input  logic                    key_neg,
    input  logic                    key_enter,
    input  logic                    key_clear,
    input  logic [2:0]              func_sel,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b,
    output logic [2:0]              func,
    output logic                    valid,
    output logic                    busy_b,
    output logic [4*DIGITS-1:0]     entry_bcd,
    output logic [3:0]              entry_sgn,
    output logic                    err
);

    localparam int MAGW = $clog2(10**DIGITS);
    localparam int CNTW = $clog2(DIGITS + 1);

    function automatic logic in_range(input logic [MAGW-1:0] m, input logic s);
        int lim;
        lim = s ? (2**(WIDTH-1)) : (2**(WIDTH-1) - 1);
        return int'(m) <= lim;
    endfunction

    function automatic logic signed [WIDTH-1:0] to_twos(input logic [MAGW-1:0] m,
                                                         input logic s);
        int v;
        v = s ? -int'(m) : int'(m);
        return $signed(v[WIDTH-1:0]);
    endfunction

    function automatic logic [MAGW-1:0] mul10_add(input logic [MAGW-1:0] m,
                                                   input logic [3:0] d);
        return (m << 3) + (m << 1) + MAGW'(d);
    endfunction

    logic [3:0] ev;
    logic       ev_dig, ev_neg, ev_ent, ev_clr;

    key_edge #(.N(4)) u_key_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({key_clear, key_enter, key_neg, key_dstb}),
        .rise  (ev)
    );

    assign ev_dig = ev[0];
    assign ev_neg = ev[1];
    assign ev_ent = ev[2];
    assign ev_clr = ev[3];

    // Digit value aligned with the registered strobe event.
    logic [3:0] digit_q;

    always_ff @(posedge clk) begin
        digit_q <= key_digit;
    end

    entry_state_t          state, state_nx;
    logic [MAGW-1:0]       mag;
    logic [CNTW-1:0]       count;
    logic                  sign;
    logic                  commit, range_err, dig_ok;
    logic signed [WIDTH-1:0] value;

    assign value  = to_twos(mag, sign);
    assign dig_ok = (digit_q <= 4'd9) && (count < CNTW'(DIGITS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ENTER_A;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        commit    = 1'b0;
        range_err = 1'b0;
        if (ev_clr) begin
            state_nx = ENTER_A;
        end else if (ev_ent) begin
            if (state != DONE) begin
                if (in_range(mag, sign)) begin
                    commit   = 1'b1;
                    state_nx = (state == ENTER_A) ? ENTER_B : DONE;
                end else begin
                    range_err = 1'b1;
                end
            end
        end else if ((ev_neg || ev_dig) && state == DONE) begin
            state_nx = ENTER_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            func      <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            mag       <= '0;
            count     <= '0;
            sign      <= 1'b0;
            entry_bcd <= '0;
        end else if (ev_clr) begin
            valid     <= 1'b0;
            err       <= 1'b0;
            mag       <= '0;
            count     <= '0;
            sign      <= 1'b0;
            entry_bcd <= '0;
        end else if (ev_ent) begin
            if (commit) begin
                mag       <= '0;
                count     <= '0;
                sign      <= 1'b0;
                entry_bcd <= '0;
                if (state == ENTER_A) begin
                    a <= value;
                end else begin
                    b     <= value;
                    func  <= func_sel;
                    valid <= 1'b1;
                end
            end else if (range_err) begin
                err <= 1'b1;
            end
        end else if (ev_neg) begin
            err <= 1'b0;
            // From DONE the entry is already clear, so the new A starts negative.
            if (state == DONE) begin
                valid <= 1'b0;
                sign  <= 1'b1;
            end else begin
                sign <= ~sign;
            end
        end else if (ev_dig) begin
            err <= 1'b0;
            if (state == DONE) begin
                valid <= 1'b0;
            end
            if (dig_ok) begin
                mag       <= mul10_add(mag, digit_q);
                count     <= count + 1'b1;
                entry_bcd <= {entry_bcd[4*DIGITS-5:0], digit_q};
            end
        end
    end

    assign busy_b    = (state == ENTER_B);
    assign entry_sgn = sign ? BCD_MINUS : BCD_BLANK;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: key sequences with hand-computed results.
module tb_operand_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_digit;
    logic       key_dstb, key_neg, key_enter, key_clear;
    logic [2:0] func_sel;
    logic [5:0] a, b;
    logic [2:0] func;
    logic       valid, busy_b, err;
    logic [7:0] entry_bcd;
    logic [3:0] entry_sgn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_entry dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_digit (key_digit),
        .key_dstb  (key_dstb),
        .key_neg   (key_neg),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .func_sel  (func_sel),
        .a         (a),
        .b         (b),
        .func      (func),
        .valid     (valid),
        .busy_b    (busy_b),
        .entry_bcd (entry_bcd),
        .entry_sgn (entry_sgn),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mask bits: 0=dstb 1=neg 2=enter 3=clear. Returns one negedge after the
    // event has been applied.
    task automatic press(input logic [3:0] mask, input logic [3:0] d);
        @(negedge clk);
        key_digit = d;
        {key_clear, key_enter, key_neg, key_dstb} = mask;
        @(negedge clk);
        {key_clear, key_enter, key_neg, key_dstb} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic dig(input logic [3:0] d);
        press(4'b0001, d);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a"}, 32'(a), 32'd0);
        check({tag, "_b"}, 32'(b), 32'd0);
        check({tag, "_func"}, 32'(func), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_bcd"}, 32'(entry_bcd), 32'h00);
        check({tag, "_sgn"}, 32'(entry_sgn), 32'hF);
    endtask

    localparam logic [3:0] NEG = 4'b0010;
    localparam logic [3:0] ENT = 4'b0100;
    localparam logic [3:0] CLR = 4'b1000;

    initial begin
        rst_n = 1'b0;
        key_digit = 4'd0;
        {key_clear, key_enter, key_neg, key_dstb} = 4'b0000;
        func_sel = 3'b010;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("rst");

        // 1: 12 enter, -5 enter
        dig(4'd1);
        dig(4'd2);
        check("t1_bcd12", 32'(entry_bcd), 32'h12);
        press(ENT, 4'd0);
        check("t1_a", 32'(a), 32'(6'd12));
        check("t1_busy_b", 32'(busy_b), 32'd1);
        check("t1_bcd_clr", 32'(entry_bcd), 32'h00);
        press(NEG, 4'd0);
        check("t1_sgn_minus", 32'(entry_sgn), 32'hA);
        dig(4'd5);
        press(ENT, 4'd0);
        check("t1_b", 32'(b), 32'(6'b111011));
        check("t1_func", 32'(func), 32'(3'b010));
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_busy_done", 32'(busy_b), 32'd0);
        press(ENT, 4'd0);
        check("t1_done_enter", 32'(valid), 32'd1);

        // 2: +33 and -33 are out of range
        dig(4'd3);
        check("t2_valid_drop", 32'(valid), 32'd0);
        dig(4'd3);
        press(ENT, 4'd0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_stay_a", 32'(busy_b), 32'd0);
        check("t2_bcd33", 32'(entry_bcd), 32'h33);
        check("t2_a_held", 32'(a), 32'(6'd12));
        press(NEG, 4'd0);
        check("t2_neg_clr_err", 32'(err), 32'd0);
        press(ENT, 4'd0);
        check("t2_err_m33", 32'(err), 32'd1);
        press(CLR, 4'd0);
        check("t2_clr_err", 32'(err), 32'd0);
        check("t2_clr_bcd", 32'(entry_bcd), 32'h00);
        check("t2_clr_sgn", 32'(entry_sgn), 32'hF);

        // 3: -32 legal, +32 illegal
        press(NEG, 4'd0);
        dig(4'd3);
        dig(4'd2);
        press(ENT, 4'd0);
        check("t3_a_m32", 32'(a), 32'(6'b100000));
        check("t3_no_err", 32'(err), 32'd0);
        check("t3_busy_b", 32'(busy_b), 32'd1);
        dig(4'd3);
        dig(4'd2);
        press(ENT, 4'd0);
        check("t3_err_p32", 32'(err), 32'd1);
        check("t3_still_b", 32'(busy_b), 32'd1);
        press(CLR, 4'd0);

        // 4: third digit and non-decimal key ignored
        dig(4'd4);
        dig(4'd5);
        dig(4'd6);
        dig(4'hC);
        check("t4_bcd45", 32'(entry_bcd), 32'h45);
        check("t4_no_err", 32'(err), 32'd0);
        press(CLR, 4'd0);

        // 5: clear beats digit in the same cycle
        dig(4'd7);
        press(ENT, 4'd0);
        check("t5_a7", 32'(a), 32'd7);
        press(4'b1001, 4'd8);
        check("t5_busy_b", 32'(busy_b), 32'd0);
        check("t5_bcd", 32'(entry_bcd), 32'h00);
        check("t5_a_held", 32'(a), 32'd7);

        // DONE -> neg starts a negative A; "-0" commits 0
        func_sel = 3'b101;
        dig(4'd1);
        press(ENT, 4'd0);
        dig(4'd2);
        press(ENT, 4'd0);
        check("dn_b2", 32'(b), 32'd2);
        check("dn_func", 32'(func), 32'(3'b101));
        press(NEG, 4'd0);
        check("dn_neg_valid", 32'(valid), 32'd0);
        check("dn_neg_sgn", 32'(entry_sgn), 32'hA);
        check("dn_neg_busy", 32'(busy_b), 32'd0);
        dig(4'd4);
        press(ENT, 4'd0);
        check("dn_a_m4", 32'(a), 32'(6'b111100));
        press(NEG, 4'd0);
        press(ENT, 4'd0);
        check("m0_b", 32'(b), 32'd0);
        check("m0_valid", 32'(valid), 32'd1);

        // 6: reset mid-entry of B, then a held key gives one event
        dig(4'd9);
        press(ENT, 4'd0);
        dig(4'd1);
        check("t6_pre_bcd", 32'(entry_bcd), 32'h01);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("t6");
        key_digit = 4'd3;
        key_dstb = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_hold_bcd", 32'(entry_bcd), 32'h03);
        key_dstb = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_release_bcd", 32'(entry_bcd), 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
